// File: rtl/imm_extend_pipe.sv
// Two-stage pipelined immediate extender: S1 captures and pre-decodes the
// immediate, S2 computes and holds the extended operand behind a valid/ready
// handshake with flush.
module imm_extend_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 24,
  parameter int unsigned ROT_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [IMM_W-1:0]  imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry,
  output logic              out_err
);

  localparam int unsigned ROT_W = 5;

  logic              s1_valid;
  logic [1:0]        s1_mode;
  logic [IMM_W-1:0]  s1_imm;
  logic [ROT_W-1:0]  s1_rot;
  logic              s1_sign;

  logic              s2_load;
  logic              in_fire;

  logic [DATA_W-1:0]   byte_ext;
  logic [2*DATA_W-1:0] rot_dbl;
  logic [31:0]         rot_mod;
  logic [DATA_W-1:0]   rot_val;
  logic [DATA_W-1:0]   res_data;
  logic                res_carry;
  logic                res_err;

  // S2 refills when empty or when its beat is leaving; S1 advances with it.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  // S1: capture the raw field and pre-decode rotate amount and sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 2'b00;
      s1_imm   <= '0;
      s1_rot   <= '0;
      s1_sign  <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        s1_mode <= mode;
        s1_imm  <= imm;
        s1_rot  <= {imm[11:8], 1'b0};
        s1_sign <= imm[IMM_W-1];
      end
    end
  end

  // Extension result computed from the S1 pre-decode.
  always_comb begin
    byte_ext  = DATA_W'(s1_imm[7:0]);
    rot_dbl   = {byte_ext, byte_ext};
    // Rotation amounts wrap within DATA_W; a right-rotate is a window into
    // the doubled operand.
    rot_mod   = 32'(s1_rot) % DATA_W;
    rot_val   = rot_dbl[rot_mod +: DATA_W];
    res_data  = '0;
    res_carry = 1'b0;
    res_err   = 1'b0;
    case (s1_mode)
      2'b00: begin
        if (ROT_EN != 0) begin
          res_data  = rot_val;
          res_carry = (s1_rot != '0) ? rot_val[DATA_W-1] : 1'b0;
        end else begin
          res_data = byte_ext;
        end
      end
      2'b01: res_data = DATA_W'(s1_imm[11:0]);
      2'b10: res_data = DATA_W'({{(DATA_W-IMM_W){s1_sign}}, s1_imm} << 2);
      default: res_err = 1'b1;
    endcase
  end

  // S2: output register, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (s2_load) begin
        out_valid <= s1_valid;
      end
      if (s2_load && s1_valid) begin
        out_data  <= res_data;
        out_carry <= res_carry;
        out_err   <= res_err;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed cases plus a randomized
// stream compared against a queue-based behavioural model.
module tb_imm_extend_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMM_W  = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic [IMM_W-1:0]  imm;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_carry;
  logic              out_err;

  int checks = 0;
  int errors = 0;

  // Expected beats in flight, each packed as {err, carry, data}.
  logic [33:0] exp_q[$];

  imm_extend_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W), .ROT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Reference result from the arithmetic meaning of each mode.
  function automatic logic [33:0] model(input logic [1:0] m, input logic [23:0] i);
    longint unsigned v;
    longint unsigned r;
    longint          s;
    logic [31:0]     d;
    logic            c;
    logic            e;
    d = 32'h0; c = 1'b0; e = 1'b0;
    case (m)
      2'd0: begin
        v = longint'(i & 24'hFF);
        r = 2 * longint'((i >> 8) & 24'hF);
        if (r == 0) d = 32'(v);
        else begin
          d = 32'(((v >> r) | (v << (32 - r))) & 64'hFFFF_FFFF);
          c = d[31];
        end
      end
      2'd1: d = 32'(i & 24'hFFF);
      2'd2: begin
        s = longint'(i);
        if (i >= 24'h800000) s = s - 64'sd16777216;
        d = 32'(s * 4);
      end
      default: e = 1'b1;
    endcase
    return {e, c, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every valid output against the model, track transfers.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_unexpected: got data 0x%0h with no beat expected at %0t", out_data, $time);
        end else begin
          check("stream", {30'h0, out_err, out_carry, out_data}, {30'h0, exp_q[0]});
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(mode, imm));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat with out_ready high: visible two cycles after it is offered.
  task automatic beat(input string name, input logic [1:0] m, input logic [23:0] i,
                      input logic [31:0] ed, input logic ec, input logic ee);
    step();
    in_valid = 1'b1; mode = m; imm = i;
    #1 check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    #1 check({name, "_early"}, 64'(out_valid), 64'd0);
    step();
    #1;
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_data"}, 64'(out_data), 64'(ed));
    check({name, "_carry"}, 64'(out_carry), 64'(ec));
    check({name, "_err"}, 64'(out_err), 64'(ee));
  endtask

  int idx;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; mode = 2'd0;
    imm = 24'h0004FF; out_ready = 1'b1;

    // Pin the model to hand-computed values.
    check("model_rot",    64'(model(2'd0, 24'h0004FF)), {30'h0, 2'b01, 32'hFF000000});
    check("model_norot",  64'(model(2'd0, 24'h0000FF)), {30'h0, 2'b00, 32'h000000FF});
    check("model_zext",   64'(model(2'd1, 24'hABCFFF)), {30'h0, 2'b00, 32'h00000FFF});
    check("model_bneg",   64'(model(2'd2, 24'hFFFFFE)), {30'h0, 2'b00, 32'hFFFFFFF8});
    check("model_illegal",64'(model(2'd3, 24'h123456)), {30'h0, 2'b10, 32'h0});

    // Reset holds outputs low even with input offered.
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_err",   64'(out_err),   64'd0);
    check("rst_carry", 64'(out_carry), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; in_valid = 1'b0;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      #1 check("rst_idle", 64'(out_valid), 64'd0);
    end

    beat("rot",     2'd0, 24'h0004FF, 32'hFF000000, 1'b1, 1'b0);
    beat("norot",   2'd0, 24'h0000FF, 32'h000000FF, 1'b0, 1'b0);
    beat("zext",    2'd1, 24'hABCFFF, 32'h00000FFF, 1'b0, 1'b0);
    beat("bneg",    2'd2, 24'hFFFFFE, 32'hFFFFFFF8, 1'b0, 1'b0);
    beat("bpos",    2'd2, 24'h000003, 32'h0000000C, 1'b0, 1'b0);
    beat("illegal", 2'd3, 24'h123456, 32'h00000000, 1'b0, 1'b1);

    // Back-pressure: five mode-01 beats with the consumer stalled for 4 cycles.
    idx = 1;
    for (int k = 0; k < 12; k++) begin
      step();
      in_valid  = (idx <= 5);
      mode      = 2'd1;
      imm       = 24'(idx);
      out_ready = (k >= 4);
      #1;
      if (k == 2 || k == 3) begin
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_hold",     64'(out_data), 64'h1);
        check("bp_accepted", 64'(idx - 1),  64'd2);
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("bp_all_sent", 64'(idx), 64'd6);
    check("bp_drained",  64'(exp_q.size()), 64'd0);

    // Flush with two beats in flight and a third offered.
    out_ready = 1'b0;
    step(); in_valid = 1'b1; mode = 2'd1; imm = 24'h000011;
    step(); imm = 24'h000022;
    step(); imm = 24'h000033; flush = 1'b1;
    step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1 check("flush_kill0", 64'(out_valid), 64'd0);
    step();
    #1 check("flush_kill1", 64'(out_valid), 64'd0);
    // Flush coinciding with an accepted input must discard that input.
    step(); in_valid = 1'b1; imm = 24'h000044;
    step(); imm = 24'h000055; flush = 1'b1;
    #1 check("flush_in_ready", 64'(in_ready), 64'd1);
    step(); flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("flush_discard", 64'(out_valid), 64'd0);
      step();
    end
    beat("post_flush", 2'd1, 24'h000ABC, 32'h00000ABC, 1'b0, 1'b0);

    // Reset mid-stream drops in-flight beats.
    step(); in_valid = 1'b1; mode = 2'd1; imm = 24'h7;
    step(); imm = 24'h8;
    step(); in_valid = 1'b0; rst_n = 1'b0;
    #1 check("midrst_valid", 64'(out_valid), 64'd0);
    step(); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      #1 check("midrst_idle", 64'(out_valid), 64'd0);
    end

    // Randomized traffic with stalls and occasional flushes.
    for (int k = 0; k < 3000; k++) begin
      step();
      in_valid  = ($urandom_range(0, 3) != 0);
      mode      = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom);
      imm       = 24'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
    end
    step();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
